// File: rtl/id_pkg.sv
// Shared types for the decode-stage hazard scoreboard: op classes, in-flight
// writer entries and downstream stage indices.
package id_pkg;

    typedef enum logic [1:0] {
        OP_ALU  = 2'd0,
        OP_LOAD = 2'd1,
        OP_MUL  = 2'd2,
        OP_RSV  = 2'd3
    } op_class_t;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
    localparam int STG_W   = 4;

    typedef struct packed {
        logic             vld;
        logic [4:0]       rd;
        logic [STG_W-1:0] rdy_stage;
    } sb_entry_t;

    // First stage whose output bus holds the result; the reserved class behaves as ALU.
    function automatic logic [STG_W-1:0] rdy_stage_of(op_class_t cls, int load_stg, int mul_stg);
        case (cls)
            OP_LOAD: return STG_W'(load_stg);
            OP_MUL:  return STG_W'(mul_stg);
            default: return STG_W'(STG_EX);
        endcase
    endfunction

endpackage

// File: rtl/sb_port_match.sv
// One source port compared against every in-flight writer; the youngest
// matching entry decides between forwarding and stalling.
module sb_port_match
    import id_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int FSEL_W    = 2
) (
    input  logic [4:0]                  rs_idx,
    input  logic                        rs_used,
    input  sb_entry_t [FWD_DEPTH-1:0]   entries,
    output logic                        stall,
    output logic [FSEL_W-1:0]           fwd_sel
);

    // Walk oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        stall   = 1'b0;
        fwd_sel = '0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (rs_used && rs_idx != 5'd0 && entries[i].vld && entries[i].rd == rs_idx) begin
                if (i >= int'(entries[i].rdy_stage)) begin
                    stall   = 1'b0;
                    fwd_sel = FSEL_W'(i + 1);
                end else begin
                    stall   = 1'b1;
                    fwd_sel = '0;
                end
            end
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: shadow pipeline of in-flight writers driving
// the ID stall, per-port forwarding selects and a saturating stall counter.
module id_hazard_scoreboard
    import id_pkg::*;
#(
    parameter  int NUM_RD_PORTS   = 2,
    parameter  int FWD_DEPTH      = 3,
    parameter  int LOAD_RDY_STAGE = 1,
    parameter  int MUL_RDY_STAGE  = 1,
    parameter  int CNT_W          = 32,
    localparam int FSEL_W         = $clog2(FWD_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [5*NUM_RD_PORTS-1:0]      id_rs_idx,
    input  logic [NUM_RD_PORTS-1:0]        id_rs_used,
    input  logic [4:0]                     id_rd_idx,
    input  logic                           id_reg_wr,
    input  logic [1:0]                     id_op_class,
    input  logic                           pipe_advance,
    input  logic                           flush,
    output logic                           id_stall,
    output logic [FSEL_W*NUM_RD_PORTS-1:0] fwd_sel,
    output logic [CNT_W-1:0]               stall_count
);

    sb_entry_t [FWD_DEPTH-1:0] ents, ents_nxt;
    logic [NUM_RD_PORTS-1:0]   port_stall;
    logic                      push;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        sb_port_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .FSEL_W    (FSEL_W)
        ) u_match (
            .rs_idx  (id_rs_idx[5*p +: 5]),
            .rs_used (id_rs_used[p]),
            .entries (ents),
            .stall   (port_stall[p]),
            .fwd_sel (fwd_sel[FSEL_W*p +: FSEL_W])
        );
    end

    assign id_stall = id_valid & ~flush & (|port_stall);
    assign push     = id_valid & ~id_stall & ~flush & id_reg_wr & (id_rd_idx != 5'd0);

    // A flush squashes the EX entry: cleared in place on a hold, or on its way into MEM.
    always_comb begin
        ents_nxt = ents;
        if (pipe_advance) begin
            for (int i = 1; i < FWD_DEPTH; i++) begin
                ents_nxt[i] = ents[i-1];
                if (i == STG_MEM && flush)
                    ents_nxt[i].vld = 1'b0;
            end
            ents_nxt[0] = '0;
            if (push) begin
                ents_nxt[0].vld       = 1'b1;
                ents_nxt[0].rd        = id_rd_idx;
                ents_nxt[0].rdy_stage = rdy_stage_of(op_class_t'(id_op_class),
                                                     LOAD_RDY_STAGE, MUL_RDY_STAGE);
            end
        end else if (flush) begin
            ents_nxt[0].vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ents        <= '0;
            stall_count <= '0;
        end else begin
            ents <= ents_nxt;
            if (id_stall && !(&stall_count))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule
